// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the iterative multiply/divide unit.
//   - mdu_op_e    : operation encodings carried on the 2-bit op port
//   - mdu_state_e : controller states
//   - sign_fix()  : conditional two's-complement negation of a magnitude
package mdu_pkg;

    // sign_fix works on a fixed wide vector; callers size-cast in and out.
    // This bounds the supported operand width at MDU_FIX_W/2.
    localparam int unsigned MDU_FIX_W = 128;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'd0,
        MDU_MULTU = 2'd1,
        MDU_DIV   = 2'd2,
        MDU_DIVU  = 2'd3
    } mdu_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIX,
        ST_DONE
    } mdu_state_e;

    function automatic logic [MDU_FIX_W-1:0] sign_fix(
        input logic [MDU_FIX_W-1:0] mag,
        input logic                 neg
    );
        return neg ? -mag : mag;
    endfunction

endpackage

// File: rtl/mdu_iter_div_step.sv
// div_step: one restoring radix-2 division iteration (combinational).
//   rem_in  : partial remainder, WIDTH+1 bits
//   dvd_bit : next dividend bit, shifted in at the LSB
//   divisor : divisor magnitude
//   rem_out : updated partial remainder
//   q_bit   : quotient bit produced by this iteration
module div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic             dvd_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_out,
    output logic             q_bit
);

    logic [WIDTH+1:0] diff;

    always_comb begin
        // Trial subtraction one bit wider than the shifted remainder so the
        // top bit is a clean borrow/sign indicator.
        diff    = {rem_in, dvd_bit} - {2'b00, divisor};
        q_bit   = ~diff[WIDTH+1];
        rem_out = q_bit ? diff[WIDTH:0] : {rem_in[WIDTH-1:0], dvd_bit};
    end

endmodule

// File: rtl/mdu_iter.sv
// mdu_iter: multi-cycle signed/unsigned multiply and divide for the EX stage.
//   clk, rst     : clock, asynchronous active-high reset
//   start, op    : request and operation (sampled only in IDLE)
//   a, b         : operands, latched on an accepted start
//   annul        : abort any in-flight operation
//   busy         : high whenever the unit is not IDLE
//   done         : one-cycle pulse, hilo updated in the same cycle
//   hilo         : {HI,LO} = product or {remainder, quotient}
//   div_by_zero  : pulses with done when a divide had b = 0
// Latency (start cycle = 0): MUL 2, DIV WIDTH+2, divide-by-zero 1.
// WIDTH must be in 4..64.
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [1:0]           op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 annul,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   hilo,
    output logic                 div_by_zero
);

    localparam int unsigned CW = $clog2(WIDTH);

    mdu_state_e           state_q, state_d;
    mdu_op_e              op_q, op_d;
    logic                 sa_q, sa_d;
    logic                 sb_q, sb_d;
    logic [WIDTH-1:0]     mag_a_q, mag_a_d;
    logic [WIDTH-1:0]     mag_b_q, mag_b_d;
    logic [WIDTH:0]       rem_q, rem_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   hilo_q, hilo_d;
    logic                 done_q, done_d;
    logic                 dbz_q, dbz_d;
    logic                 busy_q, busy_d;

    logic                 in_signed;
    logic                 op_signed;
    logic [WIDTH-1:0]     in_mag_a;
    logic [WIDTH-1:0]     in_mag_b;
    logic [2*WIDTH-1:0]   prod;
    logic [WIDTH:0]       step_rem;
    logic                 step_q;
    logic [WIDTH-1:0]     quot_fix;
    logic [WIDTH-1:0]     rem_fix;

    // mag_a_q doubles as the dividend shift register: its MSB feeds the
    // next iteration and quotient bits enter at the LSB, so after WIDTH
    // steps it holds the quotient magnitude.
    div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .rem_in  (rem_q),
        .dvd_bit (mag_a_q[WIDTH-1]),
        .divisor (mag_b_q),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    always_comb begin
        in_signed = (op == MDU_MULT) || (op == MDU_DIV);
        op_signed = (op_q == MDU_MULT) || (op_q == MDU_DIV);
        // The most-negative operand maps to 2^(WIDTH-1), which still fits
        // an unsigned WIDTH-bit magnitude.
        in_mag_a  = WIDTH'(sign_fix(MDU_FIX_W'(a), in_signed & a[WIDTH-1]));
        in_mag_b  = WIDTH'(sign_fix(MDU_FIX_W'(b), in_signed & b[WIDTH-1]));
        prod      = (2*WIDTH)'(mag_a_q) * (2*WIDTH)'(mag_b_q);
        // Most-negative / -1 needs no special case: the quotient magnitude
        // 2^(WIDTH-1) with no negation already reads as most-negative.
        quot_fix  = WIDTH'(sign_fix(MDU_FIX_W'(mag_a_q), op_signed & (sa_q ^ sb_q)));
        rem_fix   = WIDTH'(sign_fix(MDU_FIX_W'(rem_q[WIDTH-1:0]), op_signed & sa_q));
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        mag_a_d = mag_a_q;
        mag_b_d = mag_b_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        hilo_d  = hilo_q;
        done_d  = 1'b0;
        dbz_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start && !annul) begin
                    op_d    = mdu_op_e'(op);
                    sa_d    = a[WIDTH-1];
                    sb_d    = b[WIDTH-1];
                    mag_a_d = in_mag_a;
                    mag_b_d = in_mag_b;
                    rem_d   = '0;
                    if (!op[1]) begin
                        state_d = ST_MUL;
                    end else if (b == '0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        dbz_d   = 1'b1;
                        hilo_d  = {a, {WIDTH{1'b1}}};
                    end else begin
                        state_d = ST_DIV;
                        cnt_d   = CW'(WIDTH-1);
                    end
                end
            end
            ST_MUL: begin
                hilo_d  = (2*WIDTH)'(sign_fix(MDU_FIX_W'(prod), op_signed & (sa_q ^ sb_q)));
                done_d  = 1'b1;
                state_d = ST_DONE;
            end
            ST_DIV: begin
                rem_d   = step_rem;
                mag_a_d = {mag_a_q[WIDTH-2:0], step_q};
                if (cnt_q == '0) begin
                    state_d = ST_FIX;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_FIX: begin
                hilo_d  = {rem_fix, quot_fix};
                done_d  = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // In DONE the pulse is already on the outputs and the next state is
        // IDLE anyway, so annul only needs to cancel the working states.
        if (annul && state_q != ST_IDLE && state_q != ST_DONE) begin
            state_d = ST_IDLE;
            done_d  = 1'b0;
            dbz_d   = 1'b0;
            hilo_d  = hilo_q;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= MDU_MULT;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            mag_a_q <= '0;
            mag_b_q <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            hilo_q  <= '0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            mag_a_q <= mag_a_d;
            mag_b_q <= mag_b_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            hilo_q  <= hilo_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
            busy_q  <= busy_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign hilo        = hilo_q;
    assign div_by_zero = dbz_q;

endmodule

// File: doc/mdu_iter.md
# mdu_iter

Parametrised multi-cycle multiply/divide unit for the EX stage. It executes signed and unsigned multiply and divide on WIDTH-bit operands. It returns a 2·WIDTH-bit {HI,LO} result through a start/done handshake, and raises a busy output that the hazard unit converts into a pipeline stall. Over the previous single-width ALU divider path it adds an annul (exception flush) input, defined divide-by-zero and signed-overflow results, and a fixed, documented latency.

## Interface
- WIDTH, 32, operand width; must be ≥ 4.
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous and active-high.
- start  in  1  request; sampled only in IDLE.
- op  in  2  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU; sampled with start.
- a  in  WIDTH  multiplicand / dividend; latched on accepted start.
- b  in  WIDTH  multiplier / divisor; latched on accepted start.
- annul  in  1  abort in-flight operation (exception or branch flush).
- busy  out  1  high whenever state ≠ IDLE.
- done  out  1  one-cycle pulse; result is valid and updated in this cycle.
- hilo  out  2·WIDTH  {HI,LO}: product, or {remainder, quotient}; held until the next done.
- div_by_zero  out  1  pulses with done when a divide had b = 0.

## Operation
- Reset: state IDLE, busy 0, done 0, hilo 0, div_by_zero 0, iteration counter 0.
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE, start=1, annul=0: latch op/a/b and go to the next state by op.
  - MULT/MULTU → MUL.
  - DIV/DIVU with b=0 → DONE.
  - DIV/DIVU otherwise → DIV, counter = WIDTH-1.
- start is ignored in every state other than IDLE, including DONE.
- MUL: form the magnitude product (signed ops negate negative operands). On exit apply the sign (a[MSB]^b[MSB], signed ops only), write hilo, go to DONE.
- DIV: restoring radix-2 on magnitudes, one quotient bit per cycle, MSB first. At counter 0 go to FIX; otherwise decrement.
- FIX (signed only):
  - Quotient negated if a[MSB]^b[MSB].
  - Remainder takes the sign of the dividend.
  - Write hilo = {rem, quot}. Go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- Divide by zero: hilo = {a, all-ones}; div_by_zero=1 with done.
- Signed overflow, most-negative ÷ -1: quotient = most-negative, remainder 0. No flag.
- Width rules:
  - Product is the full 2·WIDTH bits.
  - Magnitude of the most-negative operand is 2^(WIDTH-1); magnitude registers are WIDTH bits unsigned.
  - Partial remainder is WIDTH+1 bits.
- annul=1 in any state: next state IDLE, no done, hilo and div_by_zero unchanged.
  - annul has priority over start.
  - annul in the DONE cycle does not suppress the done already being driven.
- rst asserted mid-operation: immediate return to the reset values.

## Timing
- Cycle 0 is the cycle in which start is accepted.
- MULT/MULTU: done in cycle 2.
- DIV/DIVU: done in cycle WIDTH+2, i.e. cycle 34 at WIDTH=32.
  - WIDTH DIV cycles occupy cycles 1..WIDTH; FIX is cycle WIDTH+1.
  - FIX is traversed for unsigned divides too, so the latency is identical.
- Divide by zero: done in cycle 1.
- busy covers cycle 1 through the done cycle inclusive.
- The earliest next start is the cycle after done, so the back-to-back issue interval is latency+1.
- done, div_by_zero, busy and hilo are registered outputs, with no combinational path from inputs.

## Structure
- Package mdu_pkg:
  - op encodings: MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU.
  - state enum.
  - sign-fix function taking a magnitude and a negate flag.
- Sub-module div_step: one restoring iteration. Inputs are the partial remainder, the next dividend bit and the divisor magnitude; outputs are the new remainder and the quotient bit. It is combinational and instantiated once in the top level.
- The multiply uses the `*` operator on magnitudes in MUL; synthesis infers DSPs.

## Test plan
- MULT a=0xFFFFFFFD (-3), b=5 → done in cycle 2, hilo=0xFFFFFFFF_FFFFFFF1; MULTU a=0xFFFFFFFF, b=2 → hilo=0x00000001_FFFFFFFE.
- DIV a=7, b=0xFFFFFFFE (-2) → done in cycle 34, hilo={0x00000001, 0xFFFFFFFD}; DIVU same operands → {0x00000007, 0x00000000}.
- DIV a=0x80000000, b=0xFFFFFFFF → hilo={0x00000000, 0x80000000}, div_by_zero=0.
- DIVU a=0x1234, b=0 → done and div_by_zero in cycle 1, hilo={0x00001234, 0xFFFFFFFF}.
- Start DIV, annul in cycle 10 → busy=0 from cycle 11, no done; hilo keeps its prior value. start with a second op during busy is ignored.
- Random 10k ops of mixed op type, with annul and rst injected at random cycles → compare against a reference model using the $signed operators; check done count and latency per op.
